// File: rtl/display_pkg.sv
// Shared display constants and cursor FSM state type for the 800x600 display path.
//   H_DISPLAY / V_DISPLAY : visible area size, also the cursor clamp bounds
//   CUR_SIZE              : edge length of the square cursor, in pixels
//   POS_W                 : width of beam and cursor position buses
//   DELTA_W               : width of the PS/2 movement deltas
//   cur_state_t           : cursor commit FSM states
package display_pkg;

  localparam int H_DISPLAY = 800;
  localparam int V_DISPLAY = 600;
  localparam int CUR_SIZE  = 16;
  localparam int POS_W     = 11;
  localparam int DELTA_W   = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRTY  = 2'd1,
    COMMIT = 2'd2
  } cur_state_t;

endpackage

// File: rtl/cursor_clamp.sv
// Applies one signed PS/2 delta to an unsigned cursor coordinate and saturates
// the result to [0, LIMIT]. NEGATE selects pos - delta (used for y, where PS/2
// reports positive as "up" but the screen grows downward).
//   pos    : current coordinate, unsigned
//   delta  : signed two's-complement delta
//   result : saturated new coordinate
module cursor_clamp
  import display_pkg::*;
#(
  parameter int LIMIT  = H_DISPLAY - 1,
  parameter bit NEGATE = 1'b0
) (
  input  logic        [POS_W-1:0]   pos,
  input  logic signed [DELTA_W-1:0] delta,
  output logic        [POS_W-1:0]   result
);

  // One guard bit over the position width holds every reachable sum
  // (-256 .. 1055) without wrapping.
  localparam int SUM_W = POS_W + 1;
  localparam logic signed [SUM_W-1:0] LIM_S = SUM_W'(LIMIT);

  logic signed [SUM_W-1:0] pos_s;
  logic signed [SUM_W-1:0] delta_s;
  logic signed [SUM_W-1:0] sum_s;

  function automatic logic [POS_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1])
      return '0;
    else if (v > LIM_S)
      return POS_W'(LIMIT);
    else
      return v[POS_W-1:0];
  endfunction

  assign pos_s   = $signed({1'b0, pos});
  assign delta_s = $signed({{(SUM_W-DELTA_W){delta[DELTA_W-1]}}, delta});

  always_comb begin
    if (NEGATE)
      sum_s = pos_s - delta_s;
    else
      sum_s = pos_s + delta_s;
  end

  assign result = saturate(sum_s);

endmodule

// File: rtl/cursor_ctrl.sv
// Mouse-cursor controller between the PS/2 packet decoder and the sync
// generator. Movement packets accumulate into a clamped pending position; the
// pending position and buttons are committed once per frame at the start of
// vertical blank so the cursor never tears. The hit flag and colour are
// registered to line up with the sync generator's registered hsync/vsync.
//   clk, rst_n            : pixel clock, asynchronous active-low reset
//   pkt_valid/pkt_ready   : packet handshake from the PS/2 decoder
//   pkt_dx, pkt_dy        : signed deltas (+x right, +y up)
//   pkt_xovf, pkt_yovf    : per-axis overflow, discards that axis delta
//   pkt_btn               : {middle, right, left}
//   hpos, vpos, display_on: beam position and visible flag
//   cur_x, cur_y, cur_btn : committed cursor state
//   cursor_hit/cursor_rgb : registered cursor pixel flag and colour
module cursor_ctrl
  import display_pkg::*;
#(
  parameter int H_DISPLAY = display_pkg::H_DISPLAY,
  parameter int V_DISPLAY = display_pkg::V_DISPLAY,
  parameter int CUR_SIZE  = display_pkg::CUR_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pkt_valid,
  output logic                      pkt_ready,
  input  logic signed [DELTA_W-1:0] pkt_dx,
  input  logic signed [DELTA_W-1:0] pkt_dy,
  input  logic                      pkt_xovf,
  input  logic                      pkt_yovf,
  input  logic        [2:0]         pkt_btn,
  input  logic        [POS_W-1:0]   hpos,
  input  logic        [POS_W-1:0]   vpos,
  input  logic                      display_on,
  output logic        [POS_W-1:0]   cur_x,
  output logic        [POS_W-1:0]   cur_y,
  output logic        [2:0]         cur_btn,
  output logic                      cursor_hit,
  output logic        [2:0]         cursor_rgb
);

  localparam int SUM_W = POS_W + 1;

  cur_state_t state_q, state_d;

  logic        [POS_W-1:0]   pend_x, pend_y;
  logic        [2:0]         pend_btn;
  logic        [POS_W-1:0]   nxt_x, nxt_y;
  logic signed [DELTA_W-1:0] dx_eff, dy_eff;
  logic                      accept;
  logic                      fe;

  logic        [SUM_W-1:0]   h_ext, v_ext;
  logic        [SUM_W-1:0]   x_lo, x_hi, y_lo, y_hi;
  logic                      hit_p0;
  logic        [2:0]         rgb_p0;
  logic                      hit_p1;
  logic        [2:0]         rgb_p1;

  assign pkt_ready = (state_q != COMMIT);
  assign accept    = pkt_valid && pkt_ready;
  assign fe        = (vpos == POS_W'(V_DISPLAY)) && (hpos == '0);

  assign dx_eff = pkt_xovf ? '0 : pkt_dx;
  assign dy_eff = pkt_yovf ? '0 : pkt_dy;

  cursor_clamp #(
    .LIMIT  (H_DISPLAY - 1),
    .NEGATE (1'b0)
  ) u_clamp_x (
    .pos    (pend_x),
    .delta  (dx_eff),
    .result (nxt_x)
  );

  // PS/2 y grows upward, screen y grows downward.
  cursor_clamp #(
    .LIMIT  (V_DISPLAY - 1),
    .NEGATE (1'b1)
  ) u_clamp_y (
    .pos    (pend_y),
    .delta  (dy_eff),
    .result (nxt_y)
  );

  // A packet arriving in the frame-event cycle is accepted and rides along
  // into the commit, so IDLE can jump straight to COMMIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && fe)
          state_d = COMMIT;
        else if (accept)
          state_d = DIRTY;
      end
      DIRTY: begin
        if (fe)
          state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: hit test against the committed position only, widened so the
  // far edge of the square cannot overflow near the screen border.
  always_comb begin
    h_ext  = {1'b0, hpos};
    v_ext  = {1'b0, vpos};
    x_lo   = {1'b0, cur_x};
    y_lo   = {1'b0, cur_y};
    x_hi   = x_lo + SUM_W'(CUR_SIZE - 1);
    y_hi   = y_lo + SUM_W'(CUR_SIZE - 1);
    hit_p0 = display_on && (h_ext >= x_lo) && (h_ext <= x_hi)
                        && (v_ext >= y_lo) && (v_ext <= y_hi);
    rgb_p0 = cur_btn[0] ? 3'b100 : 3'b111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_x   <= POS_W'(H_DISPLAY / 2);
      pend_y   <= POS_W'(V_DISPLAY / 2);
      pend_btn <= '0;
      cur_x    <= POS_W'(H_DISPLAY / 2);
      cur_y    <= POS_W'(V_DISPLAY / 2);
      cur_btn  <= '0;
      hit_p1   <= 1'b0;
      rgb_p1   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pend_x   <= nxt_x;
        pend_y   <= nxt_y;
        pend_btn <= pkt_btn;
      end
      if (state_q == COMMIT) begin
        cur_x   <= pend_x;
        cur_y   <= pend_y;
        cur_btn <= pend_btn;
      end
      // Stage p1: registered outputs aligned with registered hsync/vsync.
      hit_p1 <= hit_p0;
      rgb_p1 <= rgb_p0;
    end
  end

  assign cursor_hit = hit_p1;
  assign cursor_rgb = rgb_p1;

endmodule

// File: tb/tb_cursor_ctrl.sv
module tb_cursor_ctrl;
  import display_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pkt_valid;
  logic              pkt_ready;
  logic signed [8:0] pkt_dx, pkt_dy;
  logic              pkt_xovf, pkt_yovf;
  logic [2:0]        pkt_btn;
  logic [10:0]       hpos, vpos;
  logic              display_on;
  logic [10:0]       cur_x, cur_y;
  logic [2:0]        cur_btn;
  logic              cursor_hit;
  logic [2:0]        cursor_rgb;

  always #5 clk = ~clk;

  cursor_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_dx     (pkt_dx),
    .pkt_dy     (pkt_dy),
    .pkt_xovf   (pkt_xovf),
    .pkt_yovf   (pkt_yovf),
    .pkt_btn    (pkt_btn),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .cur_btn    (cur_btn),
    .cursor_hit (cursor_hit),
    .cursor_rgb (cursor_rgb)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; bit hit; int rgb; } hit_t;
  typedef struct { int due; int x; int y; int btn; } com_t;
  hit_t hit_q[$];
  com_t com_q[$];

  // Reference model: pending and committed cursor as plain integers.
  int m_px, m_py, m_pbtn, m_cx, m_cy, m_cbtn;
  bit m_dirty, m_commit;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lim);
    if (v < 0) return 0;
    if (v > lim) return lim;
    return v;
  endfunction

  task automatic model_reset();
    m_px = H_DISPLAY / 2; m_py = V_DISPLAY / 2; m_pbtn = 0;
    m_cx = H_DISPLAY / 2; m_cy = V_DISPLAY / 2; m_cbtn = 0;
    m_dirty = 0; m_commit = 0;
    hit_q.delete();
    com_q.delete();
  endtask

  // Drives all inputs for one clock cycle and advances the model across the
  // edge that ends it. acc reports whether the model expects the packet taken.
  task automatic drive(input int h, input int v, input bit don, input bit pv,
                       input int dx, input int dy, input bit xo, input bit yo,
                       input int btn, output bit acc);
    hit_t hi;
    com_t ce;
    @(posedge clk); #1;
    hpos = 11'(h); vpos = 11'(v); display_on = don;
    pkt_valid = pv; pkt_dx = 9'(dx); pkt_dy = 9'(dy);
    pkt_xovf = xo; pkt_yovf = yo; pkt_btn = 3'(btn);
    hi.due = cyc + 1;
    hi.hit = don && (h >= m_cx) && (h < m_cx + CUR_SIZE) && (v >= m_cy) && (v < m_cy + CUR_SIZE);
    hi.rgb = (m_cbtn & 1) ? 4 : 7;
    hit_q.push_back(hi);
    acc = pv && !m_commit;
    if (m_commit) begin
      m_cx = m_px; m_cy = m_py; m_cbtn = m_pbtn;
      m_commit = 0;
    end else begin
      if (acc) begin
        m_px = clampi(m_px + (xo ? 0 : dx), H_DISPLAY - 1);
        m_py = clampi(m_py - (yo ? 0 : dy), V_DISPLAY - 1);
        m_pbtn = btn;
        m_dirty = 1;
      end
      if (v == V_DISPLAY && h == 0 && m_dirty) begin
        ce.due = cyc + 1; ce.x = m_px; ce.y = m_py; ce.btn = m_pbtn;
        com_q.push_back(ce);
        m_commit = 1;
        m_dirty = 0;
      end
    end
  endtask

  task automatic idle(input int h, input int v);
    bit a;
    drive(h, v, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic pkt(input int dx, input int dy, input bit xo, input bit yo, input int btn);
    bit a;
    drive(50, 100, 0, 1, dx, dy, xo, yo, btn, a);
  endtask

  task automatic frame();
    idle(0, V_DISPLAY);
    idle(1, V_DISPLAY);
    idle(2, V_DISPLAY);
  endtask

  // Monitor: hit flags are popped when due; a low pkt_ready marks a commit,
  // whose committed values are checked on the following cycle.
  com_t cexp;
  hit_t hexp;
  bit   chk_com = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk_com = 0;
      end else begin
        if (hit_q.size() > 0 && hit_q[0].due <= cyc) begin
          hexp = hit_q.pop_front();
          chk("cursor_hit", int'(cursor_hit), int'(hexp.hit));
          if (hexp.hit) chk("cursor_rgb", int'(cursor_rgb), hexp.rgb);
        end
        if (chk_com) begin
          chk_com = 0;
          chk("commit_x", int'(cur_x), cexp.x);
          chk("commit_y", int'(cur_y), cexp.y);
          chk("commit_btn", int'(cur_btn), cexp.btn);
          chk("ready_low_one_cycle", int'(pkt_ready), 1);
        end
        if (!pkt_ready) begin
          if (com_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_commit: pkt_ready low at cycle %0d, no commit expected", cyc);
          end else begin
            cexp = com_q.pop_front();
            chk("commit_cycle", cyc, cexp.due);
            chk_com = 1;
          end
        end
      end
    end
  end

  initial begin
    bit a;
    int h, v;
    pkt_valid = 0; pkt_dx = '0; pkt_dy = '0; pkt_xovf = 0; pkt_yovf = 0; pkt_btn = '0;
    hpos = '0; vpos = '0; display_on = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1;

    chk("rst_cur_x", int'(cur_x), 400);
    chk("rst_cur_y", int'(cur_y), 300);
    chk("rst_cur_btn", int'(cur_btn), 0);
    chk("rst_pkt_ready", int'(pkt_ready), 1);
    chk("rst_cursor_hit", int'(cursor_hit), 0);
    chk("rst_cursor_rgb", int'(cursor_rgb), 0);

    // Hit window around the reset position (400,300).
    drive(400, 300, 1, 0, 0, 0, 0, 0, 0, a);
    drive(415, 300, 1, 0, 0, 0, 0, 0, 0, a);
    chk("hit_400_300", int'(cursor_hit), 1);
    drive(416, 300, 1, 0, 0, 0, 0, 0, 0, a);
    chk("hit_415", int'(cursor_hit), 1);
    drive(399, 300, 1, 0, 0, 0, 0, 0, 0, a);
    chk("hit_416", int'(cursor_hit), 0);
    drive(400, 315, 1, 0, 0, 0, 0, 0, 0, a);
    drive(400, 316, 1, 0, 0, 0, 0, 0, 0, a);
    idle(0, 0);

    // Deferred commit.
    pkt(10, 5, 0, 0, 0);
    idle(60, 100);
    idle(70, 200);
    chk("deferred_x_hold", int'(cur_x), 400);
    idle(0, V_DISPLAY);
    idle(1, V_DISPLAY);
    chk("commit_cycle_x_hold", int'(cur_x), 400);
    idle(2, V_DISPLAY);
    chk("deferred_x", int'(cur_x), 410);
    chk("deferred_y", int'(cur_y), 295);

    // Clamping.
    pkt(-255, 0, 0, 0, 0); pkt(-255, 0, 0, 0, 0); frame();
    chk("clamp_x_low", int'(cur_x), 0);
    repeat (4) pkt(255, 0, 0, 0, 0);
    frame();
    chk("clamp_x_high", int'(cur_x), 799);
    pkt(0, 255, 0, 0, 0); pkt(0, 255, 0, 0, 0); frame();
    chk("clamp_y_low", int'(cur_y), 0);

    // Packet in the fe cycle while DIRTY, then a packet refused during COMMIT.
    pkt(-100, 0, 0, 0, 0);
    drive(0, V_DISPLAY, 0, 1, 3, 0, 0, 0, 0, a);
    chk("collide_ready_fe", int'(pkt_ready), 1);
    drive(1, V_DISPLAY, 0, 1, 7, 0, 0, 0, 0, a);
    chk("collide_ready_commit", int'(pkt_ready), 0);
    idle(2, V_DISPLAY);
    chk("collide_ready_after", int'(pkt_ready), 1);
    chk("collide_x", int'(cur_x), 702);

    // X overflow discards dx only.
    pkt(100, -20, 1, 0, 1); frame();
    chk("ovf_x", int'(cur_x), 702);
    chk("ovf_y", int'(cur_y), 20);
    chk("ovf_btn", int'(cur_btn), 1);
    drive(702, 20, 1, 0, 0, 0, 0, 0, 0, a);
    idle(0, 0);
    chk("ovf_hit", int'(cursor_hit), 1);
    chk("ovf_rgb", int'(cursor_rgb), 4);

    // Square near the bottom-right corner, masked by display_on.
    pkt(88, -255, 0, 0, 0); pkt(0, -255, 0, 0, 0); pkt(0, -60, 0, 0, 0); frame();
    chk("corner_x", int'(cur_x), 790);
    chk("corner_y", int'(cur_y), 590);
    drive(805, 595, 0, 0, 0, 0, 0, 0, 0, a);
    drive(795, 595, 1, 0, 0, 0, 0, 0, 0, a);
    chk("mask_off_edge", int'(cursor_hit), 0);
    idle(0, 0);
    chk("corner_hit", int'(cursor_hit), 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        h = 0; v = V_DISPLAY;
      end else begin
        h = m_cx + int'($urandom_range(0, 40)) - 12;
        v = m_cy + int'($urandom_range(0, 40)) - 12;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
      end
      drive(h, v, (h < H_DISPLAY) && (v < V_DISPLAY) && ($urandom_range(0, 5) != 0),
            $urandom_range(0, 2) == 0,
            int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 7)), a);
    end
    frame();

    // Reset in the middle of operation; packet presented during reset is lost.
    pkt(20, 0, 0, 0, 5);
    @(posedge clk); #3;
    rst_n = 0;
    model_reset();
    pkt_valid = 1; pkt_dx = 9'sd50;
    #1;
    chk("midrst_cur_x", int'(cur_x), 400);
    chk("midrst_ready", int'(pkt_ready), 1);
    repeat (2) @(posedge clk);
    #1; pkt_valid = 0;
    @(negedge clk); rst_n = 1;
    pkt(0, 0, 0, 0, 0); frame();
    chk("post_rst_x", int'(cur_x), 400);
    chk("post_rst_y", int'(cur_y), 300);
    chk("post_rst_btn", int'(cur_btn), 0);
    idle(0, 0); idle(0, 0);

    chk("commits_outstanding", com_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
